// File: rtl/cache_axi_wr_if.sv
// cache_axi_wr_if: AXI4 write channels (AW, W, B) between the cache write bridge and the interconnect.
// master: drives AW/W payloads and valids plus bready.
// slave : drives awready, wready, bid, bresp and bvalid.
interface cache_axi_wr_if;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [1:0]   awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/cache_axi_wr.sv
// cache_axi_wr: one-entry buffered AXI write master for Dcache line writebacks and uncached stores.
// Ports:
//   i_aclk, i_aresetn            clock, asynchronous active-low reset
//   i_wr_req/type/addr/wstrb/data cache write request (line = type[2], else single beat)
//   o_wr_rdy                     buffer free, request taken on i_wr_req && o_wr_rdy
//   o_wr_pending(_addr)          transaction in flight and its line address [31:4]
//   axi                          AXI write master (AW/W/B)
module cache_axi_wr #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic                  i_aclk,
    input  logic                  i_aresetn,
    input  logic                  i_wr_req,
    input  logic [2:0]            i_wr_type,
    input  logic [31:0]           i_wr_addr,
    input  logic [3:0]            i_wr_wstrb,
    input  logic [127:0]          i_wr_data,
    output logic                  o_wr_rdy,
    output logic                  o_wr_pending,
    output logic [27:0]           o_wr_pending_addr,
    cache_axi_wr_if.master        axi
);
    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
    state_t         r_state, w_next;
    logic [2:0]     r_type;
    logic [31:0]    r_addr;
    logic [3:0]     r_wstrb;
    logic [127:0]   r_data;
    logic [1:0]     r_cnt;
    logic           w_line, w_last, w_unused;
    assign w_line = r_type[2];
    // Payloads come straight from the buffer so they stay stable while a valid waits.
    assign axi.awaddr  = w_line ? {r_addr[31:4], 4'h0} : r_addr;
    assign axi.awlen   = w_line ? 8'd3 : 8'd0;
    // A 2'b11 size code has no 8-byte path on a 32-bit bus, so it is sent as a word.
    assign axi.awsize  = (w_line || &r_type[1:0]) ? 3'b010 : {1'b0, r_type[1:0]};
    assign axi.wstrb   = w_line ? 4'hf : r_wstrb;
    assign axi.wdata   = w_line ? r_data[{r_cnt, 5'b0} +: 32] : r_data[31:0];
    assign w_last      = {6'd0, r_cnt} == axi.awlen;
    assign axi.wlast   = (r_state == W) && w_last;
    assign axi.awid    = AXI_ID;
    assign axi.wid     = AXI_ID;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'h0;
    assign axi.awprot  = 3'h0;
    assign o_wr_pending      = r_state != IDLE;
    assign o_wr_pending_addr = r_addr[31:4];
    assign w_unused    = ^{axi.bid, axi.bresp};
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) r_state <= IDLE;
        else            r_state <= w_next;
    end
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_type  <= '0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == IDLE && i_wr_req) begin
                r_type  <= i_wr_type;
                r_addr  <= i_wr_addr;
                r_wstrb <= i_wr_wstrb;
                r_data  <= i_wr_data;
            end
            if (r_state == AW && axi.awready)     r_cnt <= '0;
            else if (r_state == W && axi.wready)  r_cnt <= r_cnt + 2'd1;
        end
    end
    always_comb begin
        w_next      = r_state;
        o_wr_rdy    = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        case (r_state)
            IDLE: begin
                o_wr_rdy = 1'b1;
                w_next   = i_wr_req ? AW : IDLE;
            end
            AW: begin
                axi.awvalid = 1'b1;
                w_next      = axi.awready ? W : AW;
            end
            W: begin
                axi.wvalid = 1'b1;
                w_next     = (axi.wready && w_last) ? B : W;
            end
            B: begin
                axi.bready = 1'b1;
                w_next     = axi.bvalid ? IDLE : B;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_axi_wr.sv
// tb_cache_axi_wr: directed and randomized write transactions checked against a transaction-level model.
module tb_cache_axi_wr;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy, wr_pending;
  logic [27:0]  wr_pending_addr;
  int           n_vec = 0, n_err = 0;
  logic [2:0]   nt;
  logic [31:0]  na;
  logic [3:0]   ns;
  logic [127:0] nd;
  always #5 clk = ~clk;
  cache_axi_wr_if axi ();
  cache_axi_wr #(.AXI_ID(4'd1)) dut (
    .i_aclk(clk), .i_aresetn(rst_n), .i_wr_req(wr_req), .i_wr_type(wr_type),
    .i_wr_addr(wr_addr), .i_wr_wstrb(wr_wstrb), .i_wr_data(wr_data), .o_wr_rdy(wr_rdy),
    .o_wr_pending(wr_pending), .o_wr_pending_addr(wr_pending_addr), .axi(axi)
  );
  function automatic void chk(input string tag, input bit ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s", tag);
    end
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run_txn(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                         input logic [127:0] d, input int aw_stall, input int wmode,
                         input int bdelay, input logic [1:0] br, input bit busy, input int rst_beat);
    bit           line, w;
    int           n, bytes, cyc, beat, wst, pat;
    logic [31:0]  ea;
    logic [7:0]   el;
    logic [2:0]   es;
    logic [3:0]   estrb;
    logic [127:0] sh;
    line  = t[2];
    n     = line ? 4 : 1;
    bytes = line ? 4 : (1 << t[1:0]);
    if (bytes > 4) bytes = 4;
    es    = 3'($clog2(bytes));
    ea    = line ? (a & 32'hFFFF_FFF0) : a;
    el    = 8'(n - 1);
    estrb = line ? 4'hf : s;
    chk("idle_rdy", wr_rdy === 1'b1);
    chk("idle_pend", wr_pending === 1'b0);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    step;
    cyc = 1;
    wr_req = 1'b0; wr_type = 3'($urandom); wr_addr = $urandom; wr_wstrb = 4'($urandom); wr_data = rnd128();
    for (int k = 0; k <= aw_stall; k++) begin
      axi.awready = (k == aw_stall);
      axi.bvalid  = 1'($urandom);
      chk("awvalid", axi.awvalid === 1'b1);
      chk("awaddr", axi.awaddr === ea);
      chk("awlen", axi.awlen === el);
      chk("awsize", axi.awsize === es);
      chk("aw_wvalid", axi.wvalid === 1'b0);
      chk("aw_rdy", wr_rdy === 1'b0);
      chk("aw_pend", wr_pending === 1'b1);
      chk("aw_pend_addr", wr_pending_addr === a[31:4]);
      step;
      cyc++;
    end
    axi.awready = 1'b0;
    beat = 0; wst = 0; pat = 0;
    while (beat < n && wst < 40) begin
      if (rst_beat > 0 && beat == rst_beat) begin
        rst_n = 1'b0;
        #1;
        chk("rst_awvalid", axi.awvalid === 1'b0);
        chk("rst_wvalid", axi.wvalid === 1'b0);
        chk("rst_bready", axi.bready === 1'b0);
        chk("rst_rdy", wr_rdy === 1'b1);
        chk("rst_pend", wr_pending === 1'b0);
        #2;
        rst_n = 1'b1;
        axi.wready = 1'b0;
        axi.bvalid = 1'b0;
        step;
        return;
      end
      w = (wmode == 0) ? 1'b1 : (wmode == 1) ? (pat % 3 == 0) : 1'($urandom);
      pat++;
      axi.wready = w;
      axi.bvalid = 1'($urandom);
      if (busy) begin
        wr_req = 1'b1; wr_type = nt; wr_addr = na; wr_wstrb = ns; wr_data = nd;
      end
      sh = d >> (32 * beat);
      chk("wvalid", axi.wvalid === 1'b1);
      chk("w_awvalid", axi.awvalid === 1'b0);
      chk("wdata", axi.wdata === (line ? sh[31:0] : d[31:0]));
      chk("wstrb", axi.wstrb === estrb);
      chk("wlast", axi.wlast === (beat == n - 1));
      chk("w_rdy", wr_rdy === 1'b0);
      chk("w_pend", wr_pending === 1'b1);
      chk("w_pend_addr", wr_pending_addr === a[31:4]);
      step;
      cyc++;
      if (w) beat++;
      else   wst++;
    end
    if (beat < n) chk("w_timeout", beat == n);
    axi.wready = 1'b0;
    for (int k = 0; k <= bdelay; k++) begin
      axi.bvalid = (k == bdelay);
      axi.bresp  = br;
      axi.bid    = 4'($urandom);
      chk("bready", axi.bready === 1'b1);
      chk("b_wvalid", axi.wvalid === 1'b0);
      chk("b_awvalid", axi.awvalid === 1'b0);
      chk("b_rdy", wr_rdy === 1'b0);
      chk("b_pend", wr_pending === 1'b1);
      chk("b_pend_addr", wr_pending_addr === a[31:4]);
      step;
      cyc++;
    end
    axi.bvalid = 1'b0;
    chk("done_rdy", wr_rdy === 1'b1);
    chk("done_pend", wr_pending === 1'b0);
    chk("done_bready", axi.bready === 1'b0);
    chk("latency", cyc == 3 + aw_stall + n + wst + bdelay);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = '0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_rdy", wr_rdy === 1'b1);
    chk("rst_awvalid", axi.awvalid === 1'b0);
    chk("rst_wvalid", axi.wvalid === 1'b0);
    chk("rst_bready", axi.bready === 1'b0);
    chk("rst_wlast", axi.wlast === 1'b0);
    chk("rst_pend", wr_pending === 1'b0);
    chk("rst_awaddr", axi.awaddr === 32'h0);
    chk("rst_wdata", axi.wdata === 32'h0);
    chk("rst_pend_addr", wr_pending_addr === 28'h0);
    chk("rst_awlen", axi.awlen === 8'h0);
    chk("rst_awsize", axi.awsize === 3'h0);
    chk("rst_wstrb", axi.wstrb === 4'h0);
    chk("awburst", axi.awburst === 2'b01);
    chk("awlock", axi.awlock === 2'b00);
    chk("awcache", axi.awcache === 4'h0);
    chk("awprot", axi.awprot === 3'h0);
    chk("awid", axi.awid === 4'd1);
    chk("wid", axi.wid === 4'd1);
    #1 rst_n = 1'b1;
    step;
    run_txn(3'b100, 32'h1C00_0014, 4'h0, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},
            0, 0, 0, 2'b00, 1'b0, 0);
    run_txn(3'b000, 32'hBFAF_F003, 4'b1000, {96'h0, 32'h5A00_0000}, 0, 0, 0, 2'b00, 1'b0, 0);
    run_txn(3'b100, $urandom, 4'h0, rnd128(), 3, 1, 0, 2'b00, 1'b0, 0);
    nt = 3'b010; na = $urandom; ns = 4'($urandom); nd = rnd128();
    run_txn(3'b100, $urandom, 4'h0, rnd128(), 0, 0, 1, 2'b00, 1'b1, 0);
    run_txn(nt, na, ns, nd, 0, 0, 0, 2'b00, 1'b0, 0);
    wr_req = 1'b0;
    run_txn(3'b100, $urandom, 4'h0, rnd128(), 0, 0, 0, 2'b00, 1'b0, 2);
    run_txn(3'b010, $urandom, 4'hf, rnd128(), 0, 0, 0, 2'b00, 1'b0, 0);
    run_txn(3'b010, $urandom, 4'h3, rnd128(), 0, 0, 2, 2'b10, 1'b0, 0);
    run_txn(3'b011, $urandom, 4'hf, rnd128(), 1, 0, 0, 2'b11, 1'b0, 0);
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 4);
      run_txn(r == 4 ? 3'b100 : 3'(r), $urandom, 4'($urandom), rnd128(),
              $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
              2'($urandom), 1'b0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
